dmem_responder: RTL and testbench

//  Responder end of the datapath's load/store memory interface.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Access size encoding; 2'b11 is left unnamed because it is illegal.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    localparam int DMEM_WORD_BYTES = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a right-aligned request and a 32-bit RAM word:
// write byte mask, replicated write data, extended load data, alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    // Select the addressed byte and half-word lanes of the RAM word.
    always_comb begin
        lane8  = addr_i[1] ? (addr_i[0] ? rword_i[31:24] : rword_i[23:16])
                           : (addr_i[0] ? rword_i[15:8]  : rword_i[7:0]);
        lane16 = addr_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Mask, write-data replication and load extension per access size.
    // An illegal size yields an empty mask; the top flags it as an error.
    always_comb begin
        be_o         = 4'b0000;
        wword_o      = 32'h0;
        rdata_o      = 32'h0;
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & lane8[7]}}, lane8};
            end
            SZ_HALF: begin
                misaligned_o = addr_i[0];
                be_o         = addr_i[1] ? 4'b1100 : 4'b0011;
                wword_o      = {2{wdata_i[15:0]}};
                rdata_o      = {{16{~unsigned_i & lane16[15]}}, lane16};
            end
            SZ_WORD: begin
                misaligned_o = (addr_i != 2'b00);
                be_o         = 4'b1111;
                wword_o      = wdata_i;
                rdata_o      = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the load/store interface. One request outstanding at a time.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// valid is never withdrawn and its payload never changes until that edge.
// Stores commit and loads read the RAM on the accept edge; the response appears
// LATENCY cycles later and is held until resp_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state_o
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam int          CW         = $clog2(LATENCY + 1) + 1;
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(DMEM_WORD_BYTES);

    dmem_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     addr_off;
    logic [AW-1:0]   word_idx;
    logic            range_err;
    logic            size_err;
    logic            misaligned;
    logic            acc_err;
    logic            accept;
    logic [31:0]     rword;
    logic [3:0]      be;
    logic [31:0]     wword;
    logic [31:0]     ldata;

    // Decode the byte address relative to the window and look up the RAM word.
    always_comb begin
        addr_off  = req_addr - BASE_ADDR;
        word_idx  = addr_off[AW+1:2];
        range_err = ({1'b0, addr_off} >= SPAN_BYTES);
        size_err  = (req_size == 2'b11);
        acc_err   = size_err | misaligned | range_err;
        accept    = req_valid & (state_q == IDLE);
        rword     = mem_q[word_idx];
    end

    dmem_lane_align u_lane_align (
        .size_i       (req_size),
        .addr_i       (req_addr[1:0]),
        .unsigned_i   (req_unsigned),
        .wdata_i      (req_wdata),
        .rword_i      (rword),
        .be_o         (be),
        .wword_o      (wword),
        .rdata_o      (ldata),
        .misaligned_o (misaligned)
    );

    // State, latency counter and captured response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next state: capture the response at accept, count down the latency, wait for resp_ready.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d      = (LATENCY > 1) ? WAIT : RESP;
                    cnt_d        = CW'(LATENCY - 1);
                    resp_err_d   = acc_err;
                    resp_rdata_d = (acc_err | req_we) ? 32'h0 : ldata;
                end
            end
            WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        resp_rdata  = resp_rdata_q;
        resp_err    = resp_err_q;
        dbg_state_o = state_q;
    end

    // Masked store commit on the accept edge; errored requests leave the RAM untouched.
    always_ff @(posedge clk) begin
        if (!rst && accept && req_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1, one at LATENCY=3,
// sharing the request bus; sel routes req_valid and picks which outputs are observed.
module tb_dmem_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rr1, rv1, re1, rr3, rv3, re3;
    logic [31:0] rd1, rd3;
    logic [1:0]  st1, st3;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    assign req_ready  = sel ? rr3 : rr1;
    assign resp_valid = sel ? rv3 : rv1;
    assign resp_err   = sel ? re3 : re1;
    assign resp_rdata = sel ? rd3 : rd1;
    assign dbg_state  = sel ? st3 : st1;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .clk (clk), .rst (rst),
        .req_valid (req_valid & ~sel), .req_ready (rr1),
        .req_we (req_we), .req_addr (req_addr), .req_size (req_size),
        .req_unsigned (req_unsigned), .req_wdata (req_wdata),
        .resp_valid (rv1), .resp_ready (resp_ready),
        .resp_rdata (rd1), .resp_err (re1), .dbg_state_o (st1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .BASE_ADDR(32'h0)) u_lat3 (
        .clk (clk), .rst (rst),
        .req_valid (req_valid & sel), .req_ready (rr3),
        .req_we (req_we), .req_addr (req_addr), .req_size (req_size),
        .req_unsigned (req_unsigned), .req_wdata (req_wdata),
        .resp_valid (rv3), .resp_ready (resp_ready),
        .resp_rdata (rd3), .resp_err (re3), .dbg_state_o (st3)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request, returns the response and the accept-to-valid latency.
    // With hold>0, resp_ready stays low for hold extra cycles while stability is checked.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input int hold, output logic [31:0] rdata, output logic err,
                          output int lat, output logic stable_ok);
        logic seen;
        seen      = 1'b0;
        stable_ok = 1'b1;
        lat       = 1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        resp_ready   = (hold == 0);
        req_valid    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_accept"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hA5A5A5A5;
        req_addr  = 32'hFFFF_FFFC;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            lat++;
            @(posedge clk);
        end
        check({tag, "_resp"}, 32'(seen), 32'd1);
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rdata || resp_err !== err || req_ready)
                stable_ok = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic        er;
    int          lt;
    logic        ok;
    logic        saw_valid;

    initial begin
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_size = 2'b10; req_unsigned = 1'b0;
        req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state for both instances
        @(negedge clk);
        check("rst_state1", 32'(st1), 32'd0);
        check("rst_ready1", 32'(rr1), 32'd1);
        check("rst_valid1", 32'(rv1), 32'd0);
        check("rst_rdata1", rd1, 32'h0);
        check("rst_err1",   32'(re1), 32'd0);
        check("rst_state3", 32'(st3), 32'd0);
        check("rst_valid3", 32'(rv3), 32'd0);
        @(posedge clk); #1;

        // Word path at LATENCY=1
        do_req("t1_st", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er, lt, ok);
        check("t1_st_lat", 32'(lt), 32'd1);
        check("t1_st_err", 32'(er), 32'd0);
        check("t1_st_rd",  rd, 32'h0);
        do_req("t1_ld", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t1_ld_lat", 32'(lt), 32'd1);
        check("t1_ld_err", 32'(er), 32'd0);
        check("t1_ld_rd",  rd, 32'hDEADBEEF);

        // Byte / half extension
        do_req("t2_bs", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t2_bs_rd", rd, 32'hFFFFFFDE);
        do_req("t2_bu", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, rd, er, lt, ok);
        check("t2_bu_rd", rd, 32'h000000DE);
        do_req("t2_hs", 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t2_hs_rd", rd, 32'hFFFFBEEF);
        do_req("t2_hu", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, 0, rd, er, lt, ok);
        check("t2_hu_rd", rd, 32'h0000DEAD);

        // Partial store
        do_req("t3_st", 1'b1, 32'h11, 2'b00, 1'b0, 32'hFFFFFF55, 0, rd, er, lt, ok);
        check("t3_st_err", 32'(er), 32'd0);
        do_req("t3_ld", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t3_ld_rd", rd, 32'hDEAD55EF);
        do_req("t3_lb", 1'b0, 32'h11, 2'b00, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t3_lb_rd", rd, 32'h00000055);

        // Error cases
        do_req("t4_wmis", 1'b0, 32'h12, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t4_wmis_err", 32'(er), 32'd1);
        check("t4_wmis_rd",  rd, 32'h0);
        do_req("t4_hmis", 1'b1, 32'h11, 2'b01, 1'b0, 32'h00001234, 0, rd, er, lt, ok);
        check("t4_hmis_err", 32'(er), 32'd1);
        check("t4_hmis_rd",  rd, 32'h0);
        do_req("t4_sz3", 1'b1, 32'h10, 2'b11, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t4_sz3_err", 32'(er), 32'd1);
        do_req("t4_oor", 1'b1, 32'h1000, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t4_oor_err", 32'(er), 32'd1);
        do_req("t4_last", 1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t4_last_err", 32'(er), 32'd0);
        do_req("t4_chk", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t4_chk_err", 32'(er), 32'd0);
        check("t4_chk_rd",  rd, 32'hDEAD55EF);

        // Latency and backpressure at LATENCY=3
        sel = 1'b1;
        do_req("t5_st", 1'b1, 32'h40, 2'b10, 1'b0, 32'hCAFEF00D, 0, rd, er, lt, ok);
        check("t5_st_lat", 32'(lt), 32'd3);
        do_req("t5_ld", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 4, rd, er, lt, ok);
        check("t5_ld_lat",    32'(lt), 32'd3);
        check("t5_ld_rd",     rd, 32'hCAFEF00D);
        check("t5_stable",    32'(ok), 32'd1);
        check("t5_idle",      32'(dbg_state), 32'd0);
        check("t5_ready",     32'(req_ready), 32'd1);
        check("t5_valid_low", 32'(resp_valid), 32'd0);

        // Reset while a store is waiting out its latency
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(negedge clk);
        check("t6_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_wait", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) saw_valid = 1'b1;
        end
        check("t6_no_valid", 32'(saw_valid), 32'd0);
        check("t6_idle",     32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        do_req("t6_ld", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er, lt, ok);
        check("t6_ld_rd",  rd, 32'h12345678);
        check("t6_ld_lat", 32'(lt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
